data_mem_responder: RTL

//  Responder side of the processor's MEM-stage data-memory interface: accepts one load/store request
//  at a time over valid/ready, waits a fixed LATENCY, commits the store or fetches the load word,
//  and returns a response over valid/ready. Replaces the ideal zero-wait data memory, so the

---
 rtl/data_mem_responder_pkg.sv | 22 ++
 rtl/data_mem_responder_mem_array.sv | 42 ++++
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared constants for the MEM-stage data-memory handshake.
// Revision : 1.0
// ============================================================================
package mem_pkg;

   localparam int c_word_offset = 2;

   typedef logic [1:0] state_t;
   localparam state_t c_st_idle = 2'd0;
   localparam state_t c_st_wait = 2'd1;
   localparam state_t c_st_resp = 2'd2;

   typedef logic [1:0] err_code_t;
   localparam err_code_t c_err_none     = 2'd0;
   localparam err_code_t c_err_misalign = 2'd1;
   localparam err_code_t c_err_range    = 2'd2;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Brief    : DEPTH x DATA_W word storage, byte-enable synchronous write, synchronous read.
// Revision : 1.0
// ============================================================================
module mem_array #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 32,
   parameter int AW     = 10
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic                i_re,
   input  logic [AW-1:0]       i_addr,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_be,
   output logic [DATA_W-1:0]   o_rdata
);

   localparam int c_be_w = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < c_be_w; b++) begin
            if (i_be[b]) begin
               mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
      if (i_re) begin
         r_rdata <= mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-outstanding load/store responder with fixed LATENCY over valid/ready.
// Revision : 1.0
// ============================================================================
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err
);

   localparam int c_be_w   = DATA_W / 8;
   localparam int c_idx_w  = ADDR_W - c_word_offset;
   localparam int c_mem_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
   localparam bit c_direct = (LATENCY == 1);

   localparam logic [c_idx_w-1:0] c_depth_idx = c_idx_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_load  = c_cnt_w'(LATENCY - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

   generate
      if (LATENCY < 1) begin : g_bad_latency
         $error("data_mem_responder: LATENCY must be at least 1");
      end
   endgenerate

   state_t              r_state;
   state_t              w_next_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [c_be_w-1:0]   r_be;
   logic                r_rsp_err;
   logic                r_rd_sel;

   logic                w_accept;
   logic                w_commit;
   logic                w_c_we;
   logic [ADDR_W-1:0]   w_c_addr;
   logic [DATA_W-1:0]   w_c_wdata;
   logic [c_be_w-1:0]   w_c_be;
   err_code_t           w_err_code;
   logic                w_wr_en;
   logic                w_rd_en;
   logic [DATA_W-1:0]   w_ram_rdata;

   assign w_accept = req_valid && (r_state == c_st_idle);

   // With LATENCY==1 the commit edge is the accept edge, so the live request is used.
   assign w_commit  = c_direct ? w_accept
                               : ((r_state == c_st_wait) && (r_cnt == c_cnt_one));
   assign w_c_we    = c_direct ? req_we    : r_we;
   assign w_c_addr  = c_direct ? req_addr  : r_addr;
   assign w_c_wdata = c_direct ? req_wdata : r_wdata;
   assign w_c_be    = c_direct ? req_be    : r_be;

   always_comb begin
      w_err_code = c_err_none;
      if (w_c_addr[c_word_offset-1:0] != '0) begin
         w_err_code = c_err_misalign;
      end else if (w_c_addr[ADDR_W-1:c_word_offset] >= c_depth_idx) begin
         w_err_code = c_err_range;
      end
   end

   assign w_wr_en = w_commit &&  w_c_we && (w_err_code == c_err_none);
   assign w_rd_en = w_commit && !w_c_we && (w_err_code == c_err_none);

   mem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .AW     (c_mem_aw)
   ) mem_array (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_re    (w_rd_en),
      .i_addr  (w_c_addr[c_word_offset +: c_mem_aw]),
      .i_wdata (w_c_wdata),
      .i_be    (w_c_be),
      .o_rdata (w_ram_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (w_accept) w_next_state = c_direct ? c_st_resp : c_st_wait;
         c_st_wait: if (r_cnt == c_cnt_one) w_next_state = c_st_resp;
         c_st_resp: if (rsp_ready) w_next_state = c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      req_ready = (r_state == c_st_idle);
      rsp_valid = (r_state == c_st_resp);
      rsp_err   = r_rsp_err;
      rsp_rdata = r_rd_sel ? w_ram_rdata : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= c_cnt_load;
      end else if (r_state == c_st_wait) begin
         r_cnt <= r_cnt - c_cnt_one;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
      end else if (w_accept) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_be    <= req_be;
      end
   end

   // r_rd_sel gates the RAM output so stores, errors and idle cycles read as zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rsp_err <= 1'b0;
         r_rd_sel  <= 1'b0;
      end else if (w_commit) begin
         r_rsp_err <= (w_err_code != c_err_none);
         r_rd_sel  <= w_rd_en;
      end else if ((r_state == c_st_resp) && rsp_ready) begin
         r_rsp_err <= 1'b0;
         r_rd_sel  <= 1'b0;
      end
   end

endmodule
`default_nettype wire
